// File: rtl/bubble_sort_engine_if.sv
// Start/done handshake plus single-port RAM bus of the bubble-sort engine.
// BUBBLE_SORT_STATS_EN adds the swap_cnt / pass_cnt statistics signals.
interface bubble_sort_engine_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = (N < 2) ? 1 : $clog2(N)
);
  logic              start;
  logic              descend;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef BUBBLE_SORT_STATS_EN
  logic [15:0]       swap_cnt;
  logic [ADDR_W:0]   pass_cnt;

  modport master (
    output start, descend, mem_rdata,
    input  busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, swap_cnt, pass_cnt
  );
  modport slave (
    input  start, descend, mem_rdata,
    output busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, swap_cnt, pass_cnt
  );
`else
  modport master (
    output start, descend, mem_rdata,
    input  busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );
  modport slave (
    input  start, descend, mem_rdata,
    output busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );
`endif
endinterface

// File: rtl/bubble_sort_engine.sv
// In-place bubble sort of N unsigned words in a single-port synchronous RAM, with run-time
// direction, shrinking inner bound and early exit. BUBBLE_SORT_STATS_EN adds statistics.
module bubble_sort_engine #(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = (N < 2) ? 1 : $clog2(N)
) (
  input logic                 clk,
  input logic                 rst,
  bubble_sort_engine_if.slave bus
);
  localparam int unsigned CntW = ADDR_W + 1;
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t LastIdx = cnt_t'(N - 1);

  typedef enum logic [3:0] {
    StIdle, StPassInit, StRdA, StRdB, StCmp, StWrA, StWrB, StNextI, StPassEnd, StDone
  } state_e;

  state_e            state_q;
  cnt_t              i_q, j_q;
  logic              mode_q, swapped_q;
  logic              busy_q, done_q, rd_en_q, wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] a_q;
  // The write-data register holds operand B while it is written back in WR_A.
  logic [DATA_W-1:0] wdata_q;
`ifdef BUBBLE_SORT_STATS_EN
  logic [15:0]       swap_cnt_q;
  cnt_t              pass_cnt_q;
`endif

  cnt_t i_inc, j_inc, bound;
  logic do_swap;

  always_comb begin
    i_inc   = i_q + cnt_t'(1);
    j_inc   = j_q + cnt_t'(1);
    bound   = LastIdx - j_q;
    do_swap = mode_q ? (a_q < bus.mem_rdata) : (a_q > bus.mem_rdata);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      i_q        <= '0;
      j_q        <= '0;
      mode_q     <= 1'b0;
      swapped_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      a_q        <= '0;
      wdata_q    <= '0;
`ifdef BUBBLE_SORT_STATS_EN
      swap_cnt_q <= '0;
      pass_cnt_q <= '0;
`endif
    end else begin
      // Strobes and bus values are set for the state being entered, so outputs stay registered.
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mode_q <= bus.descend;
            j_q    <= '0;
`ifdef BUBBLE_SORT_STATS_EN
            swap_cnt_q <= '0;
            pass_cnt_q <= '0;
`endif
            if (N < 2) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StPassInit;
              busy_q  <= 1'b1;
            end
          end
        end
        StPassInit: begin
          i_q       <= '0;
          swapped_q <= 1'b0;
          state_q   <= StRdA;
          rd_en_q   <= 1'b1;
          addr_q    <= '0;
        end
        StRdA: begin
          state_q <= StRdB;
          rd_en_q <= 1'b1;
          addr_q  <= i_inc[ADDR_W-1:0];
        end
        StRdB: begin
          a_q     <= bus.mem_rdata;
          state_q <= StCmp;
        end
        StCmp: begin
          if (do_swap) begin
            state_q <= StWrA;
            wr_en_q <= 1'b1;
            addr_q  <= i_q[ADDR_W-1:0];
            wdata_q <= bus.mem_rdata;
          end else begin
            state_q <= StNextI;
          end
        end
        StWrA: begin
          swapped_q <= 1'b1;
          state_q   <= StWrB;
          wr_en_q   <= 1'b1;
          addr_q    <= i_inc[ADDR_W-1:0];
          wdata_q   <= a_q;
        end
        StWrB: begin
          state_q <= StNextI;
`ifdef BUBBLE_SORT_STATS_EN
          if (swap_cnt_q != 16'hFFFF) swap_cnt_q <= swap_cnt_q + 16'd1;
`endif
        end
        StNextI: begin
          i_q <= i_inc;
          if (i_inc < bound) begin
            state_q <= StRdA;
            rd_en_q <= 1'b1;
            addr_q  <= i_inc[ADDR_W-1:0];
          end else begin
            state_q <= StPassEnd;
          end
        end
        StPassEnd: begin
          j_q <= j_inc;
`ifdef BUBBLE_SORT_STATS_EN
          pass_cnt_q <= pass_cnt_q + cnt_t'(1);
`endif
          if (!swapped_q || (j_inc == LastIdx)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= StPassInit;
          end
        end
        StDone: begin
          if (!bus.start) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_wdata = wdata_q;
`ifdef BUBBLE_SORT_STATS_EN
  assign bus.swap_cnt  = swap_cnt_q;
  assign bus.pass_cnt  = pass_cnt_q;
`endif

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Bench for bubble_sort_engine: N=8, N=4 and N=1 instances against a queue-based sort model.
// Statistics outputs are checked only when BUBBLE_SORT_STATS_EN is defined.
module tb_bubble_sort_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bubble_sort_engine_if #(.N(8), .DATA_W(8)) if8 ();
  bubble_sort_engine_if #(.N(4), .DATA_W(8)) if4 ();
  bubble_sort_engine_if #(.N(1), .DATA_W(8)) if1 ();

  bubble_sort_engine #(.N(8), .DATA_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  bubble_sort_engine #(.N(4), .DATA_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  bubble_sort_engine #(.N(1), .DATA_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic [7:0] mem8 [8];
  logic [7:0] mem4 [4];
  int         init8 [8];
  int         init4 [4];
  logic       load8 = 1'b0;
  logic       load4 = 1'b0;

  always @(posedge clk) begin
    if (load8) begin
      for (int k = 0; k < 8; k++) mem8[k] <= init8[k][7:0];
    end else if (if8.mem_wr_en) begin
      mem8[if8.mem_addr] <= if8.mem_wdata;
    end
    if (if8.mem_rd_en) if8.mem_rdata <= mem8[if8.mem_addr];
    if (load4) begin
      for (int k = 0; k < 4; k++) mem4[k] <= init4[k][7:0];
    end else if (if4.mem_wr_en) begin
      mem4[if4.mem_addr] <= if4.mem_wdata;
    end
    if (if4.mem_rd_en) if4.mem_rdata <= mem4[if4.mem_addr];
  end
  assign if1.mem_rdata = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int r_cycles, r_wrs, r_rds;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Elements before position q that must end up after it.
  function automatic int before_cnt(input int a[8], input bit desc, input int q);
    int c = 0;
    for (int p = 0; p < q; p++) if (desc ? (a[p] < a[q]) : (a[p] > a[q])) c++;
    return c;
  endfunction

  task automatic model(input int a[8], input int n, input bit desc, output int s[8],
                       output int inv, output int passes, output int cycles);
    int q[$];
    int k = 0;
    inv = 0;
    for (int x = 0; x < n; x++) begin
      int b;
      b = before_cnt(a, desc, x);
      inv += b;
      if (b > k) k = b;
      q.push_back(a[x]);
    end
    q.sort();
    if (desc) q.reverse();
    for (int x = 0; x < 8; x++) s[x] = (x < n) ? q[x] : 0;
    passes = (k + 1 < n - 1) ? k + 1 : n - 1;
    cycles = 2 * inv;
    for (int p = 0; p < passes; p++) cycles += 2 + 4 * (n - 1 - p);
  endtask

  task automatic do_load8(input int a[8]);
    for (int k = 0; k < 8; k++) init8[k] = a[k];
    load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
  endtask

  task automatic run8(input int a[8], input bit desc, input bit toggle, input string name);
    int s[8];
    int inv, passes, cyc;
    model(a, 8, desc, s, inv, passes, cyc);
    if8.start   = 1'b1;
    if8.descend = desc;
    @(negedge clk);
    r_cycles = 0;
    r_wrs    = 0;
    for (int c = 0; c < 4000 && !if8.done; c++) begin
      if (if8.busy) r_cycles++;
      if (if8.mem_wr_en) r_wrs++;
      if (toggle && c == 10) begin
        if8.start   = 1'b0;
        if8.descend = ~desc;
      end
      if (toggle && c == 12) if8.start = 1'b1;
      @(negedge clk);
    end
    if8.descend = desc;
    check($sformatf("%s done", name), if8.done, 1);
    check($sformatf("%s busy_low", name), if8.busy, 0);
    for (int k = 0; k < 8; k++) check($sformatf("%s mem[%0d]", name, k), mem8[k], s[k]);
    check($sformatf("%s writes", name), r_wrs, 2 * inv);
    check($sformatf("%s busy_cycles", name), r_cycles, cyc);
`ifdef BUBBLE_SORT_STATS_EN
    check($sformatf("%s swap_cnt", name), if8.swap_cnt, inv);
    check($sformatf("%s pass_cnt", name), if8.pass_cnt, passes);
`endif
    repeat (2) begin
      @(negedge clk);
      check($sformatf("%s done_hold", name), if8.done, 1);
    end
    if8.start = 1'b0;
    @(negedge clk);
    check($sformatf("%s idle_done", name), if8.done, 0);
    check($sformatf("%s idle_busy", name), if8.busy, 0);
  endtask

  initial begin
    int a[8];
    int s[8];
    int inv, passes, cyc, c4, w4;
    bit found;
    if8.start = 1'b0; if8.descend = 1'b0;
    if4.start = 1'b0; if4.descend = 1'b0;
    if1.start = 1'b0; if1.descend = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy", if8.busy, 0);
    check("rst done", if8.done, 0);
    check("rst rd_en", if8.mem_rd_en, 0);
    check("rst wr_en", if8.mem_wr_en, 0);
    check("rst addr", if8.mem_addr, 0);
    check("rst wdata", if8.mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    a = '{7, 3, 5, 1, 8, 2, 6, 4};
    do_load8(a);
    run8(a, 1'b0, 1'b0, "plan_asc");
    do_load8(a);
    run8(a, 1'b1, 1'b0, "plan_desc");

    a = '{1, 2, 3, 4, 5, 6, 7, 8};
    do_load8(a);
    run8(a, 1'b0, 1'b0, "sorted");
    check("sorted no_writes", r_wrs, 0);
    check("sorted one_pass_cycles", r_cycles, 2 + 7 * 4);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 8; k++) a[k] = int'($urandom_range(0, 15));
      do_load8(a);
      run8(a, t[0], (t >= 3), $sformatf("rand%0d", t));
    end

    // Duplicates on the N=4 engine.
    init4 = '{2, 2, 1, 1};
    load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    if4.start = 1'b1;
    @(negedge clk);
    c4 = 0;
    w4 = 0;
    for (int c = 0; c < 500 && !if4.done; c++) begin
      if (if4.busy) c4++;
      if (if4.mem_wr_en) w4++;
      @(negedge clk);
    end
    a = '{2, 2, 1, 1, 0, 0, 0, 0};
    model(a, 4, 1'b0, s, inv, passes, cyc);
    check("dup done", if4.done, 1);
    for (int k = 0; k < 4; k++) check($sformatf("dup mem[%0d]", k), mem4[k], s[k]);
    check("dup writes", w4, 2 * inv);
    check("dup busy_cycles", c4, cyc);
`ifdef BUBBLE_SORT_STATS_EN
    check("dup swap_cnt", if4.swap_cnt, inv);
    check("dup pass_cnt", if4.pass_cnt, passes);
`endif
    if4.start = 1'b0;
    @(negedge clk);
    check("dup idle_done", if4.done, 0);

    // Reset during the first write-back, then sort whatever the RAM holds.
    a = '{7, 3, 5, 1, 8, 2, 6, 4};
    do_load8(a);
    if8.start   = 1'b1;
    if8.descend = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (if8.mem_wr_en) begin
        found = 1'b1;
        break;
      end
    end
    check("rstmid reached_wr_a", found, 1);
    rst       = 1'b1;
    if8.start = 1'b0;
    @(negedge clk);
    check("rstmid busy", if8.busy, 0);
    check("rstmid done", if8.done, 0);
    check("rstmid wr_en", if8.mem_wr_en, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) a[k] = int'(mem8[k]);
    run8(a, 1'b0, 1'b0, "after_rst");

    // Single-element engine: straight to DONE with no memory traffic.
    if1.start = 1'b1;
    @(negedge clk);
    check("n1 done", if1.done, 1);
    check("n1 busy", if1.busy, 0);
    check("n1 rd_en", if1.mem_rd_en, 0);
    check("n1 wr_en", if1.mem_wr_en, 0);
    @(negedge clk);
    check("n1 done_hold", if1.done, 1);
    if1.start = 1'b0;
    @(negedge clk);
    check("n1 idle_done", if1.done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
